pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV64 pipeline; drives the stall/flush pins of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC mux select.
- Detects load-use hazards and resolves taken branches/jumps from EX, trap/mret redirects from MEM, and i-/d-memory wait states.
- Holds a pending redirect when a redirect arrives while an instruction fetch is outstanding.
- Keeps stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/hazard_detect.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared encodings for the pipeline hazard/redirect controller
// Revision      : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic [1:0] PC_SEL_SEQ  = 2'd0;
  localparam logic [1:0] PC_SEL_EX   = 2'd1;
  localparam logic [1:0] PC_SEL_TRAP = 2'd2;
  localparam logic [1:0] PC_SEL_PEND = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// hazard_detect : combinational load-use comparator between ID and EX
// Revision      : 1.0
// ============================================================================
`default_nettype none

module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_re_mem,
  output logic       o_load_use
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_hit_rs2  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
  // x0 is never a real dependency even if a load targets it
  assign o_load_use = i_ex_re_mem && (i_ex_rd != REG_ZERO) && (w_hit_rs1 || w_hit_rs2);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/flush sequencer, pending-redirect latch and counters
// Revision         : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_re_mem,
  input  logic             i_ex_redirect,
  input  logic [XLEN-1:0]  i_ex_target,
  input  logic             i_mem_trap,
  input  logic [XLEN-1:0]  i_mem_trap_pc,
  input  logic             i_imem_busy,
  input  logic             i_dmem_busy,
  output logic             o_pc_stall,
  output logic [1:0]       o_pc_sel,
  output logic [XLEN-1:0]  o_pend_pc,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_stall,
  output logic             o_idex_flush,
  output logic             o_exmem_stall,
  output logic             o_exmem_flush,
  output logic             o_memwb_stall,
  output logic             o_memwb_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  ctrl_state_e      r_state;
  ctrl_state_e      w_state_nxt;
  logic [XLEN-1:0]  r_pend_pc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic            w_load_use;
  logic            w_pend_load;
  logic [XLEN-1:0] w_pend_val;
  logic            w_redirect;
  logic            w_ifid_s, w_ifid_f, w_idex_s, w_idex_f;
  logic            w_exmem_s, w_exmem_f, w_memwb_s, w_memwb_f;

  hazard_detect u_hazard_detect (
    .i_id_rs1     (i_id_rs1),
    .i_id_rs2     (i_id_rs2),
    .i_id_use_rs1 (i_id_use_rs1),
    .i_id_use_rs2 (i_id_use_rs2),
    .i_ex_rd      (i_ex_rd),
    .i_ex_re_mem  (i_ex_re_mem),
    .o_load_use   (w_load_use)
  );

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == RUN) begin
      if ((i_mem_trap || (!i_dmem_busy && i_ex_redirect)) && i_imem_busy)
        w_state_nxt = PEND;
    end else if (!i_imem_busy) begin
      w_state_nxt = RUN;
    end
  end

  always_comb begin
    o_pc_stall  = 1'b0;
    o_pc_sel    = PC_SEL_SEQ;
    w_ifid_s    = 1'b0; w_ifid_f  = 1'b0;
    w_idex_s    = 1'b0; w_idex_f  = 1'b0;
    w_exmem_s   = 1'b0; w_exmem_f = 1'b0;
    w_memwb_s   = 1'b0; w_memwb_f = 1'b0;
    w_pend_load = 1'b0;
    w_pend_val  = i_mem_trap_pc;
    w_redirect  = 1'b0;
    if (r_state == RUN) begin
      if (i_mem_trap) begin
        // MEM/WB keeps flowing so the trapping instruction commits its CSR effects
        {w_ifid_f, w_idex_f, w_exmem_f} = 3'b111;
        w_redirect = 1'b1;
        if (i_imem_busy) begin
          o_pc_stall  = 1'b1;
          w_pend_load = 1'b1;
        end else begin
          o_pc_sel = PC_SEL_TRAP;
        end
      end else if (i_dmem_busy) begin
        {o_pc_stall, w_ifid_s, w_idex_s, w_exmem_s, w_memwb_f} = 5'b11111;
      end else if (i_ex_redirect) begin
        {w_ifid_f, w_idex_f} = 2'b11;
        w_redirect = 1'b1;
        w_pend_val = i_ex_target;
        if (i_imem_busy) begin
          o_pc_stall  = 1'b1;
          w_pend_load = 1'b1;
        end else begin
          o_pc_sel = PC_SEL_EX;
        end
      end else if (w_load_use || i_imem_busy) begin
        {o_pc_stall, w_ifid_s, w_idex_f} = 3'b111;
      end
    end else begin
      // IF/ID only ever holds a wrong-path fetch while a redirect is pending
      w_ifid_f = 1'b1;
      if (i_mem_trap) begin
        {w_idex_f, w_exmem_f} = 2'b11;
        w_redirect  = 1'b1;
        w_pend_load = 1'b1;
      end else if (i_dmem_busy) begin
        {w_idex_s, w_exmem_s, w_memwb_f} = 3'b111;
      end
      if (i_imem_busy) o_pc_stall = 1'b1;
      else             o_pc_sel   = i_mem_trap ? PC_SEL_TRAP : PC_SEL_PEND;
    end
  end

  assign o_ifid_flush  = w_ifid_f;
  assign o_idex_flush  = w_idex_f;
  assign o_exmem_flush = w_exmem_f;
  assign o_memwb_flush = w_memwb_f;
  assign o_ifid_stall  = w_ifid_s  && !w_ifid_f;
  assign o_idex_stall  = w_idex_s  && !w_idex_f;
  assign o_exmem_stall = w_exmem_s && !w_exmem_f;
  assign o_memwb_stall = w_memwb_s && !w_memwb_f;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pend_pc   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pend_load) r_pend_pc   <= w_pend_val;
      if (o_pc_stall)  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_redirect)  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_pend_pc   = r_pend_pc;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : directed + randomized bench against a behavioural model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rstn;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_re_mem, ex_redirect, mem_trap, imem_busy, dmem_busy;
  logic [XLEN-1:0] ex_target, mem_trap_pc;
  logic o_pc_stall;
  logic [1:0] o_pc_sel;
  logic [XLEN-1:0] o_pend_pc;
  logic o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush;
  logic o_exmem_stall, o_exmem_flush, o_memwb_stall, o_memwb_flush;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_ex_rd(ex_rd), .i_ex_re_mem(ex_re_mem), .i_ex_redirect(ex_redirect), .i_ex_target(ex_target),
    .i_mem_trap(mem_trap), .i_mem_trap_pc(mem_trap_pc), .i_imem_busy(imem_busy), .i_dmem_busy(dmem_busy),
    .o_pc_stall(o_pc_stall), .o_pc_sel(o_pc_sel), .o_pend_pc(o_pend_pc),
    .o_ifid_stall(o_ifid_stall), .o_ifid_flush(o_ifid_flush),
    .o_idex_stall(o_idex_stall), .o_idex_flush(o_idex_flush),
    .o_exmem_stall(o_exmem_stall), .o_exmem_flush(o_exmem_flush),
    .o_memwb_stall(o_memwb_stall), .o_memwb_flush(o_memwb_flush),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: "a redirect is waiting for the fetch port" plus its target and counters
  bit              m_waiting = 0;
  logic [XLEN-1:0] m_target  = '0;
  int unsigned     m_stalls  = 0;
  int unsigned     m_flushes = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0; ex_re_mem = 0;
    ex_redirect = 0; ex_target = '0; mem_trap = 0; mem_trap_pc = '0; imem_busy = 0; dmem_busy = 0;
  endtask

  // Inputs are driven just after a negedge; one call covers one clock cycle.
  task automatic step();
    bit hazard, st_pc, s_ifid, f_ifid, s_idex, f_idex, s_exmem, f_exmem, f_memwb, redirected;
    logic [1:0] sel;
    bit nxt_wait;
    logic [XLEN-1:0] nxt_tgt;
    #1;
    hazard = ex_re_mem && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    {st_pc, s_ifid, f_ifid, s_idex, f_idex, s_exmem, f_exmem, f_memwb, redirected} = '0;
    sel = 2'd0; nxt_wait = m_waiting; nxt_tgt = m_target;
    if (!m_waiting) begin
      if (mem_trap) begin
        f_ifid = 1; f_idex = 1; f_exmem = 1; redirected = 1;
        if (imem_busy) begin st_pc = 1; nxt_wait = 1; nxt_tgt = mem_trap_pc; end
        else sel = 2'd2;
      end else if (dmem_busy) begin
        st_pc = 1; s_ifid = 1; s_idex = 1; s_exmem = 1; f_memwb = 1;
      end else if (ex_redirect) begin
        f_ifid = 1; f_idex = 1; redirected = 1;
        if (imem_busy) begin st_pc = 1; nxt_wait = 1; nxt_tgt = ex_target; end
        else sel = 2'd1;
      end else if (hazard || imem_busy) begin
        st_pc = 1; s_ifid = 1; f_idex = 1;
      end
    end else begin
      f_ifid = 1;
      if (mem_trap) begin f_idex = 1; f_exmem = 1; redirected = 1; nxt_tgt = mem_trap_pc; end
      else if (dmem_busy) begin s_idex = 1; s_exmem = 1; f_memwb = 1; end
      if (imem_busy) st_pc = 1;
      else begin sel = mem_trap ? 2'd2 : 2'd3; nxt_wait = 0; end
    end
    check_val("pc_stall", 64'(o_pc_stall), 64'(st_pc));
    check_val("pc_sel", 64'(o_pc_sel), 64'(sel));
    check_val("stage_ctrl",
              64'({o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
                   o_exmem_stall, o_exmem_flush, o_memwb_stall, o_memwb_flush}),
              64'({s_ifid, f_ifid, s_idex, f_idex, s_exmem, f_exmem, 1'b0, f_memwb}));
    @(posedge clk);
    if (!rstn) begin
      m_waiting = 0; m_target = '0; m_stalls = 0; m_flushes = 0;
    end else begin
      m_waiting = nxt_wait; m_target = nxt_tgt;
      if (st_pc) m_stalls++;
      if (redirected) m_flushes++;
    end
    #1;
    check_val("pend_pc", o_pend_pc, m_target);
    check_val("stall_cnt", 64'(o_stall_cnt), 64'(m_stalls));
    check_val("flush_cnt", 64'(o_flush_cnt), 64'(m_flushes));
    @(negedge clk);
  endtask

  initial begin
    int unsigned base;
    idle();
    rstn = 0;
    @(negedge clk);
    step(); step();
    rstn = 1;
    check_val("reset_pend_pc", o_pend_pc, 64'd0);
    check_val("reset_cnts", 64'({o_stall_cnt, o_flush_cnt}), 64'd0);

    // Load-use on rs1, then the same pattern against x0
    ex_re_mem = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    step();
    idle(); step();
    check_val("lu_one_stall", 64'(o_stall_cnt), 64'd1);
    ex_re_mem = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    step();
    idle();

    // Branch with free fetch port
    base = m_flushes;
    ex_redirect = 1; ex_target = 64'h8000_0100;
    step();
    idle();
    check_val("br_flush_cnt", 64'(o_flush_cnt), 64'(base + 1));

    // Branch while a fetch is outstanding for 3 cycles
    ex_redirect = 1; ex_target = 64'h8000_0200; imem_busy = 1;
    step();
    ex_redirect = 0;
    step(); step();
    check_val("pend_target", o_pend_pc, 64'h8000_0200);
    imem_busy = 0;
    step();
    idle(); step();

    // Trap and branch in the same cycle
    base = m_flushes;
    mem_trap = 1; mem_trap_pc = 64'h8000_0000; ex_redirect = 1; ex_target = 64'h1234;
    step();
    idle();
    check_val("trap_one_flush", 64'(o_flush_cnt), 64'(base + 1));

    // Data-side stall hides a branch for 4 cycles
    base = m_stalls;
    dmem_busy = 1; ex_redirect = 1; ex_target = 64'h8000_0300;
    repeat (4) step();
    check_val("dmem_stall_cnt", 64'(o_stall_cnt), 64'(base + 4));
    dmem_busy = 0;
    step();
    idle();

    // Reset while a redirect is pending
    ex_redirect = 1; ex_target = 64'hdead_beef; imem_busy = 1;
    step();
    ex_redirect = 0;
    step();
    rstn = 0;
    step();
    rstn = 1; idle();
    step();
    check_val("rst_pend_pc", o_pend_pc, 64'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_re_mem   = ($urandom_range(0, 99) < 40);
      ex_redirect = ($urandom_range(0, 99) < 25);
      mem_trap    = ($urandom_range(0, 99) < 10);
      imem_busy   = ($urandom_range(0, 99) < 45);
      dmem_busy   = ($urandom_range(0, 99) < 20);
      ex_target   = {$urandom, $urandom};
      mem_trap_pc = {$urandom, $urandom};
      rstn        = ($urandom_range(0, 99) >= 2);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
